// File: rtl/axis_to_mii.sv
// AXI-Stream byte source to MII transmit nibbles, low nibble first, with a
// forced inter-frame gap and underrun signalling via TX_ER.
module axis_to_mii #(
  parameter int IFG_NIBBLES = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] saxis_tdata,
  input  logic       saxis_tvalid,
  output logic       saxis_tready,
  input  logic       saxis_tlast,
  output logic [3:0] mii_d,
  output logic       mii_en,
  output logic       mii_er
);

  localparam int CW = (IFG_NIBBLES > 1) ? $clog2(IFG_NIBBLES) : 1;
  localparam logic [CW-1:0] GAP_LAST = CW'(IFG_NIBBLES - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, GAP, DISCARD} state_t;

  state_t        state;
  logic [7:0]    buf_q;     // byte whose nibbles are in flight (or the next one, in HIGH)
  logic          last_q;    // buf_q carries tlast
  logic          end_q;     // byte in HIGH was the frame's last
  logic          und_q;     // no byte arrived while LOW was offering ready
  logic [CW-1:0] gap_cnt;
  logic          ready_c;
  logic          accept;

  always_comb begin
    ready_c = 1'b0;
    unique case (state)
      IDLE:    ready_c = 1'b1;
      LOW:     ready_c = ~last_q;
      HIGH:    ready_c = 1'b0;
      GAP:     ready_c = (gap_cnt == GAP_LAST);
      DISCARD: ready_c = 1'b1;
      default: ready_c = 1'b0;
    endcase
  end

  // Reset gates ready combinationally so no byte is taken while it is held.
  assign saxis_tready = ready_c & ~reset;
  assign accept       = saxis_tvalid & saxis_tready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      buf_q   <= '0;
      last_q  <= 1'b0;
      end_q   <= 1'b0;
      und_q   <= 1'b0;
      gap_cnt <= '0;
      mii_d   <= '0;
      mii_en  <= 1'b0;
      mii_er  <= 1'b0;
    end else begin
      mii_d  <= '0;
      mii_en <= 1'b0;
      mii_er <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= LOW;
            mii_en <= 1'b1;
            mii_d  <= saxis_tdata[3:0];
            buf_q  <= saxis_tdata;
            last_q <= saxis_tlast;
          end
        end
        LOW: begin
          state  <= HIGH;
          mii_en <= 1'b1;
          mii_d  <= buf_q[7:4];
          end_q  <= last_q;
          und_q  <= 1'b0;
          if (!last_q) begin
            if (accept) begin
              buf_q  <= saxis_tdata;
              last_q <= saxis_tlast;
            end else begin
              und_q  <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (end_q) begin
            state   <= GAP;
            gap_cnt <= '0;
          end else if (und_q) begin
            state  <= DISCARD;
            mii_en <= 1'b1;
            mii_er <= 1'b1;
          end else begin
            state  <= LOW;
            mii_en <= 1'b1;
            mii_d  <= buf_q[3:0];
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (accept) begin
              state  <= LOW;
              mii_en <= 1'b1;
              mii_d  <= saxis_tdata[3:0];
              buf_q  <= saxis_tdata;
              last_q <= saxis_tlast;
            end else begin
              state  <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        DISCARD: begin
          // Swallow the rest of the broken frame, then pay the full gap.
          if (accept && saxis_tlast) begin
            state   <= GAP;
            gap_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_mii.sv
// Directed bench for axis_to_mii: logs every output cycle at the falling edge,
// then checks nibble streams, gaps, ready pattern, underrun and reset abort.
module tb_axis_to_mii;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] saxis_tdata;
  logic       saxis_tvalid;
  logic       saxis_tready;
  logic       saxis_tlast;
  logic [3:0] mii_d;
  logic       mii_en;
  logic       mii_er;

  int total = 0;
  int bad   = 0;

  axis_to_mii #(.IFG_NIBBLES(24)) dut (
    .clock(clock), .reset(reset),
    .saxis_tdata(saxis_tdata), .saxis_tvalid(saxis_tvalid),
    .saxis_tready(saxis_tready), .saxis_tlast(saxis_tlast),
    .mii_d(mii_d), .mii_en(mii_en), .mii_er(mii_er)
  );

  always #5 clock = ~clock;

  // Log entry: {tready, er, en, d[3:0]}
  logic [6:0] lg [0:1023];
  int n = 0;
  logic log_on = 1'b0;

  always @(negedge clock) begin
    if (log_on && n < 1024) begin
      lg[n] = {saxis_tready, mii_er, mii_en, mii_d};
      n = n + 1;
    end
  end

  function automatic logic [6:0] ent(input int i);
    if (i < 0 || i >= n) return 7'bx;
    return lg[i];
  endfunction

  function automatic int find_en(input int from);
    if (from < 0) return -1;
    for (int i = from; i < n; i++)
      if (lg[i][4]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bytes are packed byte0 in bits [7:0]. After stall_after is accepted, tvalid
  // drops for 3 cycles; abort_after stops driving before that byte index.
  task automatic send(input logic [63:0] b, input int nb, input int stall_after,
                      input int abort_after);
    logic r;
    int   k;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_after) begin
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        return;
      end
      saxis_tvalid = 1'b1;
      saxis_tdata  = b[8*i +: 8];
      saxis_tlast  = (i == nb - 1);
      k = 0;
      do begin
        @(negedge clock);
        r = saxis_tready;
        @(posedge clock);
        #1;
        k++;
      end while (!r && k < 100);
      if (!r) begin
        total++;
        bad++;
        $error("FAIL accept_timeout byte=%0d observed=none expected=accept", i);
        saxis_tvalid = 1'b0;
        saxis_tlast  = 1'b0;
        return;
      end
      if (i == stall_after) begin
        saxis_tvalid = 1'b0;
        repeat (3) begin
          @(posedge clock);
          #1;
        end
      end
    end
    saxis_tvalid = 1'b0;
    saxis_tlast  = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int s, input logic [63:0] b, input int nb);
    logic [6:0] e;
    for (int i = 0; i < nb; i++) begin
      e = ent(s + 2*i);
      chk({tag, "_lo"}, {26'b0, e[5:0]}, {26'b0, 2'b01, b[8*i +: 4]});
      e = ent(s + 2*i + 1);
      chk({tag, "_hi"}, {26'b0, e[5:0]}, {26'b0, 2'b01, b[8*i+4 +: 4]});
    end
  endtask

  int m1, m2, m4, rs, s1, s2, su, sn, sa, sb;
  logic [6:0] e;

  initial begin
    reset = 1'b1; saxis_tvalid = 1'b0; saxis_tdata = '0; saxis_tlast = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_tready", {31'b0, saxis_tready}, 32'd0);
    chk("rst_en",     {31'b0, mii_en},       32'd0);
    chk("rst_d",      {28'b0, mii_d},        32'd0);
    chk("rst_er",     {31'b0, mii_er},       32'd0);

    // Two frames back to back straight out of reset
    @(posedge clock); #1;
    reset = 1'b0; log_on = 1'b1; m1 = n;
    send(64'h00000000CDABD55555, 5, -1, -1);
    send(64'h0000EFCDABD55555, 6, -1, -1);
    repeat (40) @(posedge clock);
    #1;

    // Underrun mid-frame, then a clean frame
    m2 = n;
    send(64'h0000EFCDABD55555, 6, 2, -1);
    send(64'h2211, 2, -1, -1);
    repeat (40) @(posedge clock);
    #1;

    // Reset during a frame
    send(64'h00000000CDABD55555, 5, -1, 3);
    @(posedge clock); #1;
    reset = 1'b1; rs = n;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; m4 = n;
    send(64'h2211, 2, -1, -1);
    send(64'hA5, 1, -1, -1);
    send(64'h3412, 2, -1, -1);
    repeat (40) @(posedge clock);
    #1;

    // Frame 1: starts one cycle after release, ready toggles, gap of 24
    s1 = find_en(m1);
    chk("f1_start", 32'(s1), 32'(m1 + 1));
    e = ent(m1);
    chk("idle_ready", {31'b0, e[6]}, 32'd1);
    chk_frame("f1", s1, 64'hCDABD55555, 5);
    for (int i = 0; i < 5; i++) begin
      e = ent(s1 + 2*i);
      chk("f1_rdy_low", {31'b0, e[6]}, (i < 4) ? 32'd1 : 32'd0);
      e = ent(s1 + 2*i + 1);
      chk("f1_rdy_high", {31'b0, e[6]}, 32'd0);
    end
    e = ent(s1 + 10);
    chk("f1_tail", {25'b0, e}, 32'd0);
    s2 = find_en(s1 + 10);
    chk("f1_gap", 32'(s2 - (s1 + 10)), 32'd24);
    e = ent(s2 - 1);
    chk("gap_last_rdy", {31'b0, e[6]}, 32'd1);
    e = ent(s2 - 2);
    chk("gap_mid_rdy", {31'b0, e[6]}, 32'd0);
    chk_frame("f2", s2, 64'hEFCDABD55555, 6);
    e = ent(s2 + 12);
    chk("f2_tail", {26'b0, e[5:0]}, 32'd0);

    // Underrun: 5,5,5,5,5,D then one error nibble, then discard + gap
    su = find_en(m2);
    chk_frame("ur", su, 64'hD55555, 3);
    e = ent(su + 6);
    chk("ur_err", {26'b0, e[5:0]}, 32'h30);
    e = ent(su + 7);
    chk("ur_drop", {26'b0, e[5:0]}, 32'd0);
    sn = find_en(su + 7);
    chk("ur_gap", 32'(sn - (su + 7)), 32'd26);
    chk_frame("ur_next", sn, 64'h2211, 2);
    e = ent(sn + 4);
    chk("ur_next_tail", {26'b0, e[5:0]}, 32'd0);

    // Reset abort, restart with no gap
    e = ent(rs);
    chk("rst_mid_rdy", {31'b0, e[6]}, 32'd0);
    chk("rst_mid_en_before", {31'b0, e[4]}, 32'd1);
    e = ent(rs + 1);
    chk("rst_mid_abort", {25'b0, e}, 32'd0);
    chk("rst_restart", 32'(find_en(m4)), 32'(m4 + 1));
    chk_frame("rst_f", m4 + 1, 64'h2211, 2);

    // Single-byte frame
    sa = find_en(m4 + 5);
    chk("sb_gap_before", 32'(sa - (m4 + 5)), 32'd24);
    chk_frame("sb", sa, 64'hA5, 1);
    sb = find_en(sa + 2);
    chk("sb_gap_after", 32'(sb - (sa + 2)), 32'd24);
    chk_frame("sb_next", sb, 64'h3412, 2);
    e = ent(sb + 4);
    chk("sb_next_tail", {26'b0, e[5:0]}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
